// File: rtl/tile_cfg_loader.sv
// tile_cfg_loader: streams configuration words LSB-first into either the clb
// or the conn scan chain of a row of daisy-chained tiles. The chain is selected
// at session start.
// Optional feature macro: TILE_CFG_READBACK_EN. It adds a CRC-8 readback pass
// that recirculates the chain after load.
module tile_cfg_loader #(
  parameter int unsigned CHANNEL_ONEWAY_WIDTH = 4,
  parameter int unsigned TILE_NUM             = 4,
  parameter int unsigned CLB_BITS_PER_TILE    = 32,
  parameter int unsigned CONN_BITS_PER_TILE   = 64,
  parameter int unsigned DATA_WIDTH           = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cfg_sel,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  clb_scan_in,
  output logic                  clb_scan_en,
  output logic                  conn_scan_in,
  output logic                  conn_scan_en,
  input  logic                  clb_scan_ret,
  input  logic                  conn_scan_ret,
  output logic                  scan_clk_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned N_CLB  = TILE_NUM * CLB_BITS_PER_TILE;
  localparam int unsigned N_CONN = TILE_NUM * CONN_BITS_PER_TILE;
  // The counter also covers the shortest legal conn chain (one bit per track).
  localparam int unsigned N_TRK  = TILE_NUM * CHANNEL_ONEWAY_WIDTH;
  localparam int unsigned N_MX0  = (N_CLB > N_CONN) ? N_CLB : N_CONN;
  localparam int unsigned N_MAX  = (N_MX0 > N_TRK) ? N_MX0 : N_TRK;
  localparam int unsigned CW     = $clog2(N_MAX) + 1;
  localparam int unsigned SW     = $clog2(DATA_WIDTH + 1);

`ifdef TILE_CFG_READBACK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, VERIFY = 2'd2, FINISH = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FINISH = 2'd3} state_t;
`endif

  state_t                state, state_nxt;
  logic                  sel_q, error_q, clk_en_q, scan_bit_q;
  logic [CW-1:0]         bit_cnt, n_len;
  logic [DATA_WIDTH-1:0] sh_reg;
  logic [SW-1:0]         sh_left;
  logic                  last_bit, take_word, issue, scan_bit, scan_act;

`ifdef TILE_CFG_READBACK_EN
  logic [7:0] crc_load, crc_ver;
  logic       ret_bit, verify_last, issue_bit;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  assign ret_bit     = sel_q ? conn_scan_ret : clb_scan_ret;
  assign verify_last = (bit_cnt == n_len - 1'b1);
  assign issue_bit   = take_word ? cfg_data[0] : sh_reg[0];
`else
  logic unused_ret;
  assign unused_ret = clb_scan_ret ^ conn_scan_ret;
`endif

  assign error = error_q;

  // Word handshake and per-cycle shift qualifier. Ready opens while the last
  // bit of the previous word is on the wire, so words stream without a bubble.
  always_comb begin
    n_len     = sel_q ? CW'(N_CONN) : CW'(N_CLB);
    last_bit  = (bit_cnt == n_len);
    cfg_ready = (state == LOAD) && (sh_left == '0) && !last_bit && !abort;
    take_word = cfg_valid && cfg_ready;
    issue     = (state == LOAD) && !abort && !last_bit && ((sh_left != '0) || take_word);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and chain/status outputs
  always_comb begin
    state_nxt   = state;
    busy        = (state != IDLE);
    done        = 1'b0;
    scan_act    = 1'b0;
    scan_bit    = scan_bit_q;
    scan_clk_en = clk_en_q;
    case (state)
      IDLE: if (start && !abort) state_nxt = LOAD;
      LOAD: begin
        scan_act = 1'b1;
        if (abort) state_nxt = IDLE;
`ifdef TILE_CFG_READBACK_EN
        else if (last_bit) state_nxt = VERIFY;
`else
        else if (last_bit) state_nxt = FINISH;
`endif
      end
`ifdef TILE_CFG_READBACK_EN
      VERIFY: begin
        scan_act    = 1'b1;
        scan_bit    = ret_bit;
        scan_clk_en = 1'b1;
        if (abort) state_nxt = IDLE;
        else if (verify_last) state_nxt = FINISH;
      end
`endif
      FINISH: begin
        done      = !error_q && !abort;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    clb_scan_en  = scan_act && !sel_q;
    conn_scan_en = scan_act && sel_q;
    clb_scan_in  = scan_bit && !sel_q;
    conn_scan_in = scan_bit && sel_q;
  end

  // Session datapath: chain select, shift register, bit counter, error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q      <= 1'b0;
      error_q    <= 1'b0;
      clk_en_q   <= 1'b0;
      scan_bit_q <= 1'b0;
      bit_cnt    <= '0;
      sh_reg     <= '0;
      sh_left    <= '0;
`ifdef TILE_CFG_READBACK_EN
      crc_load   <= '0;
      crc_ver    <= '0;
`endif
    end else begin
      clk_en_q <= issue;
      if (state == IDLE) begin
        sh_left <= '0;
        if (start && !abort) begin
          sel_q      <= cfg_sel;
          error_q    <= 1'b0;
          bit_cnt    <= '0;
          scan_bit_q <= 1'b0;
`ifdef TILE_CFG_READBACK_EN
          crc_load   <= '0;
`endif
        end
      end else if (abort) begin
        error_q <= 1'b1;
        sh_left <= '0;
      end else if (state == LOAD) begin
        if (take_word) begin
          scan_bit_q <= cfg_data[0];
          sh_reg     <= cfg_data >> 1;
          sh_left    <= SW'(DATA_WIDTH - 1);
        end else if (issue) begin
          scan_bit_q <= sh_reg[0];
          sh_reg     <= sh_reg >> 1;
          sh_left    <= sh_left - 1'b1;
        end
        if (issue) begin
          bit_cnt  <= bit_cnt + 1'b1;
`ifdef TILE_CFG_READBACK_EN
          crc_load <= crc8_step(crc_load, issue_bit);
`endif
        end
        // Chain full: unshifted bits of the final word are dropped here.
        if (last_bit) begin
          sh_left <= '0;
`ifdef TILE_CFG_READBACK_EN
          bit_cnt <= '0;
          crc_ver <= '0;
`endif
        end
      end
`ifdef TILE_CFG_READBACK_EN
      else if (state == VERIFY) begin
        bit_cnt <= bit_cnt + 1'b1;
        crc_ver <= crc8_step(crc_ver, ret_bit);
        if (verify_last && (crc8_step(crc_ver, ret_bit) != crc_load)) error_q <= 1'b1;
      end
`endif
    end
  end

endmodule
